// File: rtl/fp_del_fsm.sv
// fp_del_fsm: sequential IEEE-754 single-precision divider, res = n / x.
// A rising edge on r_i starts one division. Operands are latched, unpacked and
// divided by restoring division at one quotient bit per clock. The result is
// normalised, truncated toward zero and packed. r_o rises exactly 29 cycles
// after the start edge.
module fp_del_fsm #(
   parameter int ITER = 25
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] n,
   input  logic [31:0] x,
   input  logic        r_i,
   output logic [31:0] res,
   output logic        r_o
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_UNPACK = 3'd2;
   localparam logic [2:0] S_DIVIDE = 3'd3;
   localparam logic [2:0] S_NORM   = 3'd4;
   localparam logic [2:0] S_PACK   = 3'd5;
   localparam logic [2:0] S_DONE   = 3'd6;

   // Operand-pair classes, resolved in priority order
   localparam logic [1:0] C_NORMAL = 2'd0;
   localparam logic [1:0] C_NAN    = 2'd1;
   localparam logic [1:0] C_INF    = 2'd2;
   localparam logic [1:0] C_ZERO   = 2'd3;

   localparam logic [4:0] LAST_STEP = 5'(ITER - 1);

   // Classify an operand pair; denormals (exponent 0) count as zero
   function automatic logic [1:0] classify(input logic [31:0] a, input logic [31:0] b);
      logic a_nan;
      logic a_inf;
      logic a_zero;
      logic b_nan;
      logic b_inf;
      logic b_zero;
      a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      a_zero = (a[30:23] == 8'h00);
      b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      b_zero = (b[30:23] == 8'h00);
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
         classify = C_NAN;
      end else if (b_zero || a_inf) begin
         classify = C_INF;
      end else if (a_zero || b_inf) begin
         classify = C_ZERO;
      end else begin
         classify = C_NORMAL;
      end
   endfunction

   logic [2:0]        state_r;
   logic [2:0]        state_nxt_s;
   logic              r_i_d_r;
   logic              start_s;
   logic [31:0]       n_r;
   logic [31:0]       x_r;
   logic              sign_r;
   logic signed [9:0] exp_r;
   logic [1:0]        cls_r;
   logic [23:0]       mb_r;
   logic [24:0]       rem_r;
   logic [24:0]       quo_r;
   logic [4:0]        cnt_r;
   logic              rem_ge_s;
   logic [24:0]       rem_nxt_s;
   logic [31:0]       res_pack_s;
   logic [31:0]       res_r;
   logic              r_o_r;

   assign res = res_r;
   assign r_o = r_o_r;

   // Start detection and next-state selection; starts are honoured only when not busy
   always_comb begin
      start_s     = r_i & ~r_i_d_r;
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE, S_DONE: begin
            if (start_s) begin
               state_nxt_s = S_LOAD;
            end else begin
               state_nxt_s = state_r;
            end
         end
         S_LOAD:   state_nxt_s = S_UNPACK;
         S_UNPACK: state_nxt_s = S_DIVIDE;
         S_DIVIDE: begin
            if (cnt_r == LAST_STEP) begin
               state_nxt_s = S_NORM;
            end else begin
               state_nxt_s = S_DIVIDE;
            end
         end
         S_NORM:   state_nxt_s = S_PACK;
         S_PACK:   state_nxt_s = S_DONE;
         default:  state_nxt_s = S_IDLE;
      endcase
   end

   // One restoring-division step: subtract the divisor when the remainder covers it
   always_comb begin
      rem_ge_s = (rem_r >= {1'b0, mb_r});
      if (rem_ge_s) begin
         rem_nxt_s = rem_r - {1'b0, mb_r};
      end else begin
         rem_nxt_s = rem_r;
      end
   end

   // Final result assembly with special-case and exponent-range overrides
   always_comb begin
      res_pack_s = 32'h0000_0000;
      case (cls_r)
         C_NAN:  res_pack_s = 32'h7FC0_0000;
         C_INF:  res_pack_s = {sign_r, 8'hFF, 23'd0};
         C_ZERO: res_pack_s = {sign_r, 31'd0};
         C_NORMAL: begin
            if (exp_r >= 10'sd255) begin
               res_pack_s = {sign_r, 8'hFF, 23'd0};
            end else if (exp_r <= 10'sd0) begin
               res_pack_s = {sign_r, 31'd0};
            end else begin
               res_pack_s = {sign_r, exp_r[7:0], quo_r[23:1]};
            end
         end
         default: res_pack_s = 32'h0000_0000;
      endcase
   end

   // State register and the registered copy of r_i used for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
         r_i_d_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         r_i_d_r <= r_i;
      end
   end

   // Datapath: operand latch, unpack, iterative divide, normalise and pack
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_r    <= 32'd0;
         x_r    <= 32'd0;
         sign_r <= 1'b0;
         exp_r  <= 10'sd0;
         cls_r  <= C_NORMAL;
         mb_r   <= 24'd0;
         rem_r  <= 25'd0;
         quo_r  <= 25'd0;
         cnt_r  <= 5'd0;
         res_r  <= 32'd0;
         r_o_r  <= 1'b0;
      end else begin
         case (state_r)
            S_LOAD: begin
               n_r   <= n;
               x_r   <= x;
               r_o_r <= 1'b0;
            end
            S_UNPACK: begin
               sign_r <= n_r[31] ^ x_r[31];
               exp_r  <= $signed({2'b00, n_r[30:23]}) - $signed({2'b00, x_r[30:23]}) + 10'sd127;
               cls_r  <= classify(n_r, x_r);
               mb_r   <= {1'b1, x_r[22:0]};
               rem_r  <= {1'b0, 1'b1, n_r[22:0]};
               quo_r  <= 25'd0;
               cnt_r  <= 5'd0;
            end
            S_DIVIDE: begin
               // Remainder stays below twice the divisor, so the shift never loses a set bit
               quo_r <= {quo_r[23:0], rem_ge_s};
               rem_r <= rem_nxt_s << 1;
               cnt_r <= cnt_r + 5'd1;
            end
            S_NORM: begin
               // Quotient of two [1,2) mantissas lies in (0.5,2): at most one left shift
               if (!quo_r[24]) begin
                  quo_r <= quo_r << 1;
                  exp_r <= exp_r - 10'sd1;
               end else begin
                  quo_r <= quo_r;
                  exp_r <= exp_r;
               end
            end
            S_PACK: begin
               res_r <= res_pack_s;
               r_o_r <= 1'b1;
            end
            default: begin
               res_r <= res_r;
               r_o_r <= r_o_r;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_del_fsm.sv
// Self-checking bench for fp_del_fsm: a transaction-level model predicts r_o
// and res every cycle from the start/latency rules and an integer-division
// reference; directed vectors also pin literal results and latency.
module tb_fp_del_fsm;

   logic        clk;
   logic        rst_n;
   logic [31:0] n;
   logic [31:0] x;
   logic        r_i;
   logic [31:0] res;
   logic        r_o;

   int n_checks = 0;
   int n_errors = 0;

   fp_del_fsm dut (
      .clk   (clk),
      .rst_n (rst_n),
      .n     (n),
      .x     (x),
      .r_i   (r_i),
      .res   (res),
      .r_o   (r_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Truncating reference quotient computed with plain integer division
   function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      logic              s;
      logic              a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
      logic [63:0]       num, den, q;
      logic signed [15:0] e;
      logic [22:0]       frac;
      s      = a[31] ^ b[31];
      a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      a_zero = (a[30:23] == 8'h00);
      b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      b_zero = (b[30:23] == 8'h00);
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) return 32'h7FC0_0000;
      if (b_zero || a_inf) return {s, 8'hFF, 23'd0};
      if (a_zero || b_inf) return {s, 31'd0};
      num = 64'({1'b1, a[22:0]}) << 24;
      den = 64'({1'b1, b[22:0]});
      q   = num / den;
      e   = $signed({8'd0, a[30:23]}) - $signed({8'd0, b[30:23]}) + 16'sd127;
      if (q >= 64'h100_0000) begin
         frac = q[23:1];
      end else begin
         frac = q[22:0];
         e    = e - 16'sd1;
      end
      if (e >= 16'sd255) return {s, 8'hFF, 23'd0};
      if (e <= 16'sd0) return {s, 31'd0};
      return {s, e[7:0], frac};
   endfunction

   // Transaction model: a start edge when idle begins an operation whose
   // operands are captured one edge later and whose result lands 29 edges later
   logic        act_m;
   int          age_m;
   logic        prev_ri_m;
   logic [31:0] n_lat_m, x_lat_m;
   logic [31:0] exp_res_m;
   logic        exp_ro_m;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_m     <= 1'b0;
         age_m     <= 0;
         prev_ri_m <= 1'b0;
         exp_res_m <= 32'd0;
         exp_ro_m  <= 1'b0;
      end else begin
         prev_ri_m <= r_i;
         if (act_m) begin
            age_m <= age_m + 1;
            if (age_m == 0) begin
               n_lat_m  <= n;
               x_lat_m  <= x;
               exp_ro_m <= 1'b0;
            end
            if (age_m == 28) begin
               exp_res_m <= ref_div(n_lat_m, x_lat_m);
               exp_ro_m  <= 1'b1;
               act_m     <= 1'b0;
            end
         end else if (r_i && !prev_ri_m) begin
            act_m <= 1'b1;
            age_m <= 0;
         end
      end
   end

   // Cycle-by-cycle comparison of DUT outputs against the model
   always @(negedge clk) begin
      check("cyc_res", res, exp_res_m);
      check("cyc_r_o", {31'd0, r_o}, {31'd0, exp_ro_m});
   end

   // Run one division: hold r_i for 'hold' edges, optionally disturb operands
   // after they are latched, verify r_o fall, 29-cycle latency and a literal
   task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit scramble,
                        input bit chk_lit, input logic [31:0] lit);
      int done_at;
      done_at = 0;
      @(negedge clk);
      n   = a;
      x   = b;
      r_i = 1'b1;
      @(posedge clk);
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk);
         #1;
         if (i == hold) r_i = 1'b0;
         if (i == 1) begin
            check({name, "_ro_fall"}, {31'd0, r_o}, 32'd0);
            if (scramble) begin
               n = 32'h3F80_0000;
               x = 32'h4000_0000;
            end
         end
         if (r_o && done_at == 0 && i >= 2) done_at = i;
         if (done_at != 0 && i >= hold) break;
      end
      check({name, "_latency"}, 32'(done_at), 32'd29);
      if (chk_lit) check({name, "_res"}, res, lit);
      check({name, "_ro_hold"}, {31'd0, r_o}, 32'd1);
      r_i = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      n     = 32'd0;
      x     = 32'd0;
      r_i   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_res", res, 32'd0);
      check("reset_r_o", {31'd0, r_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      do_op("five_sevenths", 32'h40A0_0000, 32'h40E0_0000, 1, 1'b0, 1'b1, 32'h3F36_DB6D);
      do_op("latched",       32'h48A4_1800, 32'h44FC_00E0, 1, 1'b1, 1'b0, 32'd0);
      do_op("held_ri",       32'h44FC_00E0, 32'h48A4_1800, 35, 1'b0, 1'b0, 32'd0);
      do_op("six_two",       32'h40C0_0000, 32'h4000_0000, 1, 1'b0, 1'b1, 32'h4040_0000);
      do_op("neg_six_two",   32'hC0C0_0000, 32'h4000_0000, 1, 1'b0, 1'b1, 32'hC040_0000);

      // Abort mid-division with an asynchronous reset
      @(negedge clk);
      n   = 32'h40A0_0000;
      x   = 32'h40E0_0000;
      r_i = 1'b1;
      @(posedge clk);
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk);
         #1;
         if (i == 1) r_i = 1'b0;
      end
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_res", res, 32'd0);
      check("abort_r_o", {31'd0, r_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op("after_abort",   32'h40A0_0000, 32'h40E0_0000, 1, 1'b0, 1'b1, 32'h3F36_DB6D);

      do_op("one_by_zero",   32'h3F80_0000, 32'h0000_0000, 1, 1'b0, 1'b1, 32'h7F80_0000);
      do_op("zero_by_zero",  32'h0000_0000, 32'h0000_0000, 1, 1'b0, 1'b1, 32'h7FC0_0000);
      do_op("zero_by_two",   32'h0000_0000, 32'h4000_0000, 1, 1'b0, 1'b1, 32'h0000_0000);
      do_op("overflow",      32'h7F00_0000, 32'h0080_0000, 1, 1'b0, 1'b1, 32'h7F80_0000);
      do_op("underflow",     32'h0080_0000, 32'h7F00_0000, 1, 1'b0, 1'b1, 32'h0000_0000);
      do_op("neg_inf",       32'hFF80_0000, 32'h4000_0000, 1, 1'b0, 1'b1, 32'hFF80_0000);
      do_op("nan_in",        32'h7FC0_0001, 32'h4000_0000, 1, 1'b0, 1'b1, 32'h7FC0_0000);

      repeat (3) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
